// File: rtl/fp32_result_collector_pkg.sv
// rtl/fp32_result_collector_pkg.sv - shared constants, class codes and FSM encoding for the FP32 result collector
package fp32_result_collector_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 128;
  localparam int LOSTW_DEF       = 8;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_NORMAL = 3'd1,
    CLS_DENORM = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/fp32_result_collector_if.sv
// rtl/fp32_result_collector_if.sv - result handshake channel from the collector to parallel logic
interface fp32_result_collector_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] res_data;
  logic             res_over;
  logic             res_under;
  logic [2:0]       res_class;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data, res_over, res_under, res_class, res_err, res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data, res_over, res_under, res_class, res_err, res_valid,
    output res_ready
  );
endinterface

// File: rtl/fp32_result_collector_classify.sv
// rtl/fp32_result_collector_classify.sv - combinational FP32 word classifier
module fp32_result_collector_classify
  import fp32_result_collector_pkg::*;
(
  input  logic [31:0] i_word,
  output cls_e        o_class
);

  logic [7:0]  w_exp;
  logic [22:0] w_man;

  always_comb begin
    w_exp   = i_word[30:23];
    w_man   = i_word[22:0];
    o_class = CLS_NORMAL;
    if (w_exp == 8'h00) begin
      o_class = (w_man == 23'd0) ? CLS_ZERO : CLS_DENORM;
    end else if (w_exp == EXP_MAX) begin
      o_class = (w_man == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp32_result_collector.sv
// rtl/fp32_result_collector.sv - deserialises the bit-serial adder result and offers it over valid/ready
module fp32_result_collector
  import fp32_result_collector_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int LOSTW       = LOSTW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_shift,
  input  logic                 i_out_c,
  input  logic                 i_over,
  input  logic                 i_under,
  input  logic                 i_done,
  fp32_result_collector_if.master res,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [LOSTW-1:0]     o_lost_cnt
);

  localparam int CNTW = $clog2(WIDTH + 2);
  localparam int WDW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_sreg;
  logic [CNTW-1:0]  r_cnt;
  logic [WDW-1:0]   r_wdog;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_over;
  logic             r_res_under;
  logic [2:0]       r_res_class;
  logic             r_res_err;
  logic             r_res_valid;
  logic             r_timeout;
  logic [LOSTW-1:0] r_lost;

  logic [WIDTH-1:0] w_sreg_shift;
  logic [CNTW-1:0]  w_cnt_shift;
  logic             w_idle_cyc;
  logic             w_expire;
  logic             w_load;
  logic             w_drop;
  cls_e             w_cls;

  // The bit arriving on the done cycle is folded in before capture, so the
  // classifier looks at the post-shift register.
  fp32_result_collector_classify u_classify (
    .i_word  (w_sreg_shift[31:0]),
    .o_class (w_cls)
  );

  always_comb begin
    w_sreg_shift = i_shift ? {r_sreg[WIDTH-2:0], i_out_c} : r_sreg;
    w_cnt_shift  = (i_shift && (r_cnt != CNT_SAT)) ? r_cnt + 1'b1 : r_cnt;
    w_idle_cyc   = (r_state == ST_COLLECT) && !i_shift && !i_done;
    w_expire     = w_idle_cyc && (r_wdog == WD_LAST);
    w_load       = i_done && (!r_res_valid || res.res_ready);
    w_drop       = i_done && r_res_valid && !res.res_ready;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_shift && !i_done) w_state_next = ST_COLLECT;
      ST_COLLECT: if (i_done || w_expire) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_wdog      <= '0;
      r_res_data  <= '0;
      r_res_over  <= 1'b0;
      r_res_under <= 1'b0;
      r_res_class <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_lost      <= '0;
    end else begin
      r_timeout <= w_expire;
      r_wdog    <= (w_idle_cyc && !w_expire) ? r_wdog + 1'b1 : '0;

      if (i_done || w_expire) begin
        r_sreg <= '0;
        r_cnt  <= '0;
      end else begin
        r_sreg <= w_sreg_shift;
        r_cnt  <= w_cnt_shift;
      end

      // A capture on the same edge as an accept replaces the result in place.
      if (w_load) begin
        r_res_data  <= w_sreg_shift;
        r_res_over  <= i_over;
        r_res_under <= i_under;
        r_res_class <= w_cls;
        r_res_err   <= (w_cnt_shift != CNT_FULL);
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res.res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_drop && (r_lost != {LOSTW{1'b1}})) begin
        r_lost <= r_lost + 1'b1;
      end
    end
  end

  assign res.res_data  = r_res_data;
  assign res.res_over  = r_res_over;
  assign res.res_under = r_res_under;
  assign res.res_class = r_res_class;
  assign res.res_err   = r_res_err;
  assign res.res_valid = r_res_valid;
  assign o_busy        = (r_state == ST_COLLECT);
  assign o_timeout     = r_timeout;
  assign o_lost_cnt    = r_lost;

endmodule

// File: tb/tb_fp32_result_collector.sv
// tb/tb_fp32_result_collector.sv - directed scoreboard bench for fp32_result_collector
module tb_fp32_result_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       shift, out_c, over, under, done;
  logic       busy, tmo;
  logic [7:0] lost_cnt;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic [31:0] data;
    logic        over;
    logic        under;
    logic [2:0]  cls;
    logic        err;
  } exp_t;

  exp_t sb[$];

  fp32_result_collector_if #(.WIDTH(32)) rif ();

  fp32_result_collector #(.WIDTH(32), .TIMEOUT_CYC(128), .LOSTW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_shift    (shift),
    .i_out_c    (out_c),
    .i_over     (over),
    .i_under    (under),
    .i_done     (done),
    .res        (rif),
    .o_busy     (busy),
    .o_timeout  (tmo),
    .o_lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic o, input logic u,
                      input logic [2:0] c, input logic e);
    exp_t x;
    x.data = d; x.over = o; x.under = u; x.cls = c; x.err = e;
    sb.push_back(x);
  endtask

  // Shifts bits n-1..0 of w MSB-first; optionally raises done with the last bit.
  task automatic shift_word(input logic [63:0] w, input int n, input bit done_last);
    for (int i = n - 1; i >= 0; i--) begin
      shift = 1'b1;
      out_c = w[i];
      done  = (i == 0) && done_last;
      tick();
    end
    shift = 1'b0;
    out_c = 1'b0;
    done  = 1'b0;
  endtask

  task automatic do_done(input logic o, input logic u);
    done = 1'b1; over = o; under = u;
    tick();
    done = 1'b0; over = 1'b0; under = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit accept);
    exp_t x;
    for (int i = 0; i < 8 && rif.res_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, rif.res_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_data"},  rif.res_data,  x.data);
      chk({tag, "_over"},  rif.res_over,  x.over);
      chk({tag, "_under"}, rif.res_under, x.under);
      chk({tag, "_class"}, rif.res_class, x.cls);
      chk({tag, "_err"},   rif.res_err,   x.err);
    end
    if (accept) begin
      rif.res_ready = 1'b1;
      tick();
      rif.res_ready = 1'b0;
      chk({tag, "_drop"}, rif.res_valid, 0);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; shift = 1'b0; out_c = 1'b0; over = 1'b0; under = 1'b0; done = 1'b0;
    rif.res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", rif.res_valid, 0);
    chk("rst_data",  rif.res_data,  0);
    chk("rst_busy",  busy, 0);
    chk("rst_tmo",   tmo, 0);
    chk("rst_lost",  lost_cnt, 0);

    // 1) full word, separate done with overflow; valid one cycle after done
    shift_word(64'h7FFF_FFFF, 32, 0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", rif.res_valid, 0);
    push(32'h7FFF_FFFF, 1, 0, 3'd4, 0);
    do_done(1'b1, 1'b0);
    chk("t1_valid_lat", rif.res_valid, 1);
    chk("t1_idle", busy, 0);
    check_result("t1", 1);

    // 2) done together with the last bit
    push(32'h3F80_0000, 0, 0, 3'd1, 0);
    shift_word(64'h3F80_0000, 32, 1);
    check_result("t2", 1);

    // 3) short and long words
    shift_word(64'h0000_0001, 31, 0);
    push(32'h0000_0001, 0, 0, 3'd2, 1);
    do_done(1'b0, 1'b0);
    check_result("t3a", 1);
    shift_word(64'h1_8000_0001, 33, 0);
    push(32'h8000_0001, 0, 0, 3'd2, 1);
    do_done(1'b0, 1'b0);
    check_result("t3b", 1);

    // done in IDLE with no bits
    push(32'h0, 0, 1, 3'd0, 1);
    do_done(1'b0, 1'b1);
    check_result("t3c", 1);

    // 4) overrun while consumer stalls
    push(32'h4000_0000, 0, 0, 3'd1, 0);
    shift_word(64'h4000_0000, 32, 1);
    shift_word(64'hC000_0000, 32, 1);
    chk("t4_lost", lost_cnt, 1);
    check_result("t4", 1);

    // 5) watchdog
    shift_word(64'h3FF, 10, 0);
    k = 0;
    for (int j = 1; j <= 200; j++) begin
      tick();
      if (tmo === 1'b1) begin
        k = j;
        break;
      end
    end
    chk("t5_tmo_lat", k, 128);
    chk("t5_busy", busy, 0);
    chk("t5_novalid", rif.res_valid, 0);
    tick();
    chk("t5_pulse", tmo, 0);

    // 6) reset mid-collect clears everything including lost_cnt
    shift_word(64'hABCD, 16, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_lost", lost_cnt, 0);
    chk("t6_valid", rif.res_valid, 0);
    chk("t6_data", rif.res_data, 0);
    push(32'h0, 0, 0, 3'd0, 0);
    shift_word(64'h0, 32, 1);
    check_result("t6", 1);

    // 7) accept and new capture on the same edge keep valid high
    push(32'h7F80_0000, 0, 0, 3'd3, 0);
    shift_word(64'h7F80_0000, 32, 1);
    check_result("t7a", 0);
    shift_word(64'hFF80_0000 >> 1, 31, 0);
    shift = 1'b1; out_c = 1'b0; done = 1'b1; rif.res_ready = 1'b1;
    tick();
    shift = 1'b0; done = 1'b0; rif.res_ready = 1'b0;
    push(32'hFF80_0000, 0, 0, 3'd3, 0);
    chk("t7_lost", lost_cnt, 0);
    check_result("t7b", 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
